// File: rtl/bullet_pkg.sv
// Shared types and sizing for the bullet frame cache.
// Holds the cache entry layout and the scan FSM encoding.
package bullet_pkg;
  localparam int N_BULLETS = 8;
  localparam int IDX_W     = 3;
  localparam int COLOR_W   = 3;

  typedef struct packed {
    logic [7:0]         x;
    logic [7:0]         y;
    logic [7:0]         w;
    logic [7:0]         h;
    logic [COLOR_W-1:0] color;
    logic               render;
  } bullet_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SWAP,
    ST_CHECK
  } scan_state_t;
endpackage

// File: rtl/bullet_rect_test.sv
// Combinational rect/rect overlap of a cached entry against a probe rect (a pixel is a 1x1 probe).
// Zero latency; no flow control. 11-bit sums so edges near 255 never wrap.
module bullet_rect_test
  import bullet_pkg::*;
(
  input  bullet_entry_t ent,
  input  logic [9:0]    px,
  input  logic [9:0]    py,
  input  logic [8:0]    pw,
  input  logic [8:0]    ph,
  output logic          overlap
);
  logic [10:0] ex0, ex1, ey0, ey1;
  logic [10:0] px0, px1, py0, py1;
  logic        unused_color;

  assign unused_color = ^ent.color;

  assign ex0 = {3'b000, ent.x};
  assign ex1 = ex0 + {3'b000, ent.w};
  assign ey0 = {3'b000, ent.y};
  assign ey1 = ey0 + {3'b000, ent.h};
  assign px0 = {1'b0, px};
  assign px1 = px0 + {2'b00, pw};
  assign py0 = {1'b0, py};
  assign py1 = py0 + {2'b00, ph};

  // Invisible or zero-area entries never match anything.
  assign overlap = ent.render && (ent.w != 8'd0) && (ent.h != 8'd0) &&
                   (pw != 9'd0) && (ph != 9'd0) &&
                   (px0 < ex1) && (ex0 < px1) &&
                   (py0 < ey1) && (ey0 < py1);
endmodule

// File: rtl/bullet_frame_cache.sv
// Per-frame bullet table snapshot (double-buffered) with 1-cycle pixel hit query; no backpressure.
// Optional heart collision sweep enabled by BULLET_COLLISION_EN; otherwise collide outputs stay 0.
module bullet_frame_cache
  import bullet_pkg::*;
#(
  parameter int SCALE_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  output logic [IDX_W-1:0]   bullet_index,
  input  logic [15:0]        bullet_position,
  input  logic [15:0]        bullet_size,
  input  logic [COLOR_W-1:0] bullet_color,
  input  logic               bullet_is_render,
  input  logic               pix_valid,
  input  logic [9:0]         pix_x,
  input  logic [9:0]         pix_y,
  output logic               pixel_hit,
  output logic [COLOR_W-1:0] pixel_color,
  input  logic [15:0]        heart_position,
  input  logic [15:0]        heart_size,
  output logic               collide,
  output logic [IDX_W-1:0]   collide_index,
  output logic               scan_busy
);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(N_BULLETS);
  localparam logic [CNT_W-1:0] CHECK_LAST = CNT_W'(N_BULLETS - 1);

  scan_state_t        state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cidx_q, cidx_d;
  logic               sel_q, sel_d;
  logic               collide_q, collide_d;
  logic               pixel_hit_q, pixel_hit_d;
  logic [COLOR_W-1:0] pixel_color_q, pixel_color_d;
  bullet_entry_t      banks_q [2][N_BULLETS];
  bullet_entry_t      banks_d [2][N_BULLETS];
  bullet_entry_t      fetched;
  logic [IDX_W-1:0]   wr_idx;
  logic [N_BULLETS-1:0] pix_cover;
  logic [9:0]         gx, gy;
  logic               chk_hit;

  assign fetched = {bullet_position, bullet_size, bullet_color, bullet_is_render};
  // Bullet answers one cycle after the index, so count k stores entry k-1.
  assign wr_idx  = IDX_W'(cnt_q - CNT_ONE);
  assign gx      = pix_x >> SCALE_SHIFT;
  assign gy      = pix_y >> SCALE_SHIFT;

  for (genvar i = 0; i < N_BULLETS; i++) begin : g_pix
    bullet_rect_test u_pix (
      .ent     (banks_q[sel_q][i]),
      .px      (gx),
      .py      (gy),
      .pw      (9'd1),
      .ph      (9'd1),
      .overlap (pix_cover[i])
    );
  end

`ifdef BULLET_COLLISION_EN
  logic [IDX_W-1:0] chk_idx;
  assign chk_idx = cnt_q[IDX_W-1:0];
  bullet_rect_test u_chk (
    .ent     (banks_q[sel_q][chk_idx]),
    .px      ({2'b00, heart_position[15:8]}),
    .py      ({2'b00, heart_position[7:0]}),
    .pw      ({1'b0, heart_size[15:8]}),
    .ph      ({1'b0, heart_size[7:0]}),
    .overlap (chk_hit)
  );
`else
  logic unused_heart;
  assign unused_heart = ^{heart_position, heart_size};
  assign chk_hit      = 1'b0;
`endif

  always_comb begin
    pixel_hit_d   = 1'b0;
    pixel_color_d = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (pix_valid && pix_cover[i]) begin
        pixel_hit_d   = 1'b1;
        pixel_color_d = banks_q[sel_q][i].color;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    sel_d     = sel_q;
    banks_d   = banks_q;
    collide_d = 1'b0;
    cidx_d    = cidx_q;
    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cnt_q != '0) banks_d[~sel_q][wr_idx] = fetched;
        if (cnt_q < CHECK_LAST) idx_d = IDX_W'(cnt_q + CNT_ONE);
        if (cnt_q == SCAN_LAST) state_d = ST_SWAP;
        else                    cnt_d   = cnt_q + CNT_ONE;
      end
      ST_SWAP: begin
        sel_d = ~sel_q;
        cnt_d = '0;
`ifdef BULLET_COLLISION_EN
        state_d = ST_CHECK;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_CHECK: begin
        if (chk_hit) begin
          collide_d = 1'b1;
          cidx_d    = cnt_q[IDX_W-1:0];
          state_d   = ST_IDLE;
        end else if (cnt_q == CHECK_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      cidx_q        <= '0;
      sel_q         <= 1'b0;
      collide_q     <= 1'b0;
      pixel_hit_q   <= 1'b0;
      pixel_color_q <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < N_BULLETS; i++) banks_q[b][i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      cidx_q        <= cidx_d;
      sel_q         <= sel_d;
      collide_q     <= collide_d;
      pixel_hit_q   <= pixel_hit_d;
      pixel_color_q <= pixel_color_d;
      banks_q       <= banks_d;
    end
  end

  assign bullet_index  = idx_q;
  assign collide       = collide_q;
  assign collide_index = cidx_q;
  assign pixel_hit     = pixel_hit_q;
  assign pixel_color   = pixel_color_q;
  assign scan_busy     = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bullet_frame_cache.sv
// Directed plus randomized bench for bullet_frame_cache against a table-level reference model.
module tb_bullet_frame_cache;
  import bullet_pkg::*;

  typedef struct {
    int x; int y; int w; int h; int color; int render;
  } mb_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               frame_start = 1'b0;
  logic [IDX_W-1:0]   bullet_index;
  logic [15:0]        bullet_position = '0;
  logic [15:0]        bullet_size = '0;
  logic [COLOR_W-1:0] bullet_color = '0;
  logic               bullet_is_render = 1'b0;
  logic               pix_valid = 1'b0;
  logic [9:0]         pix_x = '0;
  logic [9:0]         pix_y = '0;
  logic               pixel_hit;
  logic [COLOR_W-1:0] pixel_color;
  logic [15:0]        heart_position = '0;
  logic [15:0]        heart_size = '0;
  logic               collide;
  logic [IDX_W-1:0]   collide_index;
  logic               scan_busy;

  int  vectors = 0;
  int  miscompares = 0;
  mb_t table_m [N_BULLETS];
  mb_t snap    [N_BULLETS];
  int  last_cidx = 0;

  always #5 clk = ~clk;

  bullet_frame_cache dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .bullet_index(bullet_index), .bullet_position(bullet_position),
    .bullet_size(bullet_size), .bullet_color(bullet_color),
    .bullet_is_render(bullet_is_render), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pixel_hit(pixel_hit), .pixel_color(pixel_color),
    .heart_position(heart_position), .heart_size(heart_size),
    .collide(collide), .collide_index(collide_index), .scan_busy(scan_busy)
  );

  // Upstream Bullet entity: registered read of its table, one cycle after the index.
  always @(posedge clk) begin
    bullet_position  <= {8'(table_m[bullet_index].x), 8'(table_m[bullet_index].y)};
    bullet_size      <= {8'(table_m[bullet_index].w), 8'(table_m[bullet_index].h)};
    bullet_color     <= 3'(table_m[bullet_index].color);
    bullet_is_render <= 1'(table_m[bullet_index].render);
  end

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit exp_pix(input int px, input int py, output int col);
    int gx, gy;
    gx = px >> 1;
    gy = py >> 1;
    col = 0;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (snap[i].render != 0 && snap[i].w > 0 && snap[i].h > 0 &&
          gx >= snap[i].x && gx < snap[i].x + snap[i].w &&
          gy >= snap[i].y && gy < snap[i].y + snap[i].h) begin
        col = snap[i].color;
        return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  function automatic int exp_col(input int hx, input int hy, input int hw, input int hh);
    if (hw == 0 || hh == 0) return -1;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (table_m[i].render != 0 && table_m[i].w > 0 && table_m[i].h > 0 &&
          hx < table_m[i].x + table_m[i].w && table_m[i].x < hx + hw &&
          hy < table_m[i].y + table_m[i].h && table_m[i].y < hy + hh)
        return i;
    end
    return -1;
  endfunction

  task automatic query(input int px, input int py, input bit valid);
    int eh, ec;
    @(negedge clk);
    pix_valid = valid;
    pix_x = 10'(px);
    pix_y = 10'(py);
    eh = valid ? int'(exp_pix(px, py, ec)) : 0;
    if (!valid) ec = 0;
    @(negedge clk);
    pix_valid = 1'b0;
    chk("pixel_hit", int'(pixel_hit), eh);
    chk("pixel_color", int'(pixel_color), ec);
  endtask

  task automatic pick_point(output int px, output int py);
    int i;
    i = $urandom_range(0, N_BULLETS - 1);
    if (snap[i].w > 0 && snap[i].h > 0 && $urandom_range(0, 3) != 0) begin
      px = ((snap[i].x + $urandom_range(0, snap[i].w - 1)) << 1) | $urandom_range(0, 1);
      py = ((snap[i].y + $urandom_range(0, snap[i].h - 1)) << 1) | $urandom_range(0, 1);
    end else begin
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
    end
  endtask

  task automatic do_frame(input bit chk_idx);
    int busy_len, npulse, pidx, qx, qy, eh, ec, e, exp_len;
    e = exp_col(int'(heart_position[15:8]), int'(heart_position[7:0]),
                int'(heart_size[15:8]), int'(heart_size[7:0]));
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    busy_len = 0; npulse = 0; pidx = -1; qx = 0; qy = 0;
    for (int c = 0; c < 100 && scan_busy; c++) begin
      if (chk_idx && c < N_BULLETS) chk("bullet_index_step", int'(bullet_index), c);
      if (c == 2) begin
        pick_point(qx, qy);
        pix_valid = 1'b1; pix_x = 10'(qx); pix_y = 10'(qy);
      end
      if (c == 3) begin
        pix_valid = 1'b0;
        eh = int'(exp_pix(qx, qy, ec));
        chk("scan_pixel_hit", int'(pixel_hit), eh);
        chk("scan_pixel_color", int'(pixel_color), ec);
        frame_start = 1'b1;
      end
      if (c == 4) frame_start = 1'b0;
      if (collide) begin npulse++; pidx = int'(collide_index); end
      busy_len++;
      @(negedge clk);
    end
    repeat (3) begin
      if (collide) begin npulse++; pidx = int'(collide_index); end
      @(negedge clk);
    end
    chk("busy_after_frame", int'(scan_busy), 0);
`ifdef BULLET_COLLISION_EN
    exp_len = (e >= 0) ? (N_BULLETS + 1) + 1 + (e + 1) : (N_BULLETS + 1) + 1 + N_BULLETS;
    chk("collide_pulses", npulse, (e >= 0) ? 1 : 0);
    if (e >= 0) begin
      chk("collide_index_pulse", pidx, e);
      last_cidx = e;
    end
`else
    exp_len = (N_BULLETS + 1) + 1;
    chk("collide_pulses", npulse, 0);
`endif
    chk("busy_len", busy_len, exp_len);
    chk("collide_index_held", int'(collide_index), last_cidx);
    snap = table_m;
  endtask

  task automatic clear_table();
    for (int i = 0; i < N_BULLETS; i++) table_m[i] = '{0, 0, 0, 0, 0, 0};
  endtask

  initial begin
    int qx, qy;
    clear_table();
    snap = table_m;
    repeat (3) @(negedge clk);
    chk("rst_bullet_index", int'(bullet_index), 0);
    chk("rst_pixel_hit", int'(pixel_hit), 0);
    chk("rst_pixel_color", int'(pixel_color), 0);
    chk("rst_collide", int'(collide), 0);
    chk("rst_collide_index", int'(collide_index), 0);
    chk("rst_scan_busy", int'(scan_busy), 0);
    rst_n = 1'b1;
    heart_position = {8'd250, 8'd250};
    heart_size     = {8'd1, 8'd1};
    query(40, 40, 1'b1);

    do_frame(1'b1);

    // Bullet1 alone; heart overlapping it.
    table_m[1] = '{10, 20, 4, 4, 4, 1};
    heart_position = {8'd12, 8'd22};
    heart_size     = {8'd2, 8'd2};
    do_frame(1'b1);
    query(20, 40, 1'b1);
    query(28, 40, 1'b1);
    query(20, 40, 1'b0);

    heart_position = {8'd100, 8'd100};
    do_frame(1'b0);

    // Overlapping bullets 2 and 5: lowest visible index wins.
    table_m[2] = '{48, 48, 4, 4, 2, 1};
    table_m[5] = '{45, 45, 10, 10, 5, 1};
    do_frame(1'b0);
    query(100, 100, 1'b1);
    table_m[2].render = 0;
    do_frame(1'b0);
    query(100, 100, 1'b1);

    // Right edge near 255: sum must not wrap.
    clear_table();
    table_m[0] = '{250, 0, 10, 10, 7, 1};
    do_frame(1'b0);
    query(6, 2, 1'b1);
    query(504, 2, 1'b1);
    query(519, 2, 1'b1);

    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N_BULLETS; i++) begin
        table_m[i].x      = $urandom_range(0, 255);
        table_m[i].y      = $urandom_range(0, 255);
        table_m[i].w      = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40);
        table_m[i].h      = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40);
        table_m[i].color  = $urandom_range(0, 7);
        table_m[i].render = $urandom_range(0, 3) != 0 ? 1 : 0;
      end
      heart_position = 16'($urandom_range(0, 65535));
      heart_size     = {8'($urandom_range(0, 30)), 8'($urandom_range(0, 30))};
      do_frame(f == 0);
      for (int q = 0; q < 12; q++) begin
        pick_point(qx, qy);
        query(qx, qy, $urandom_range(0, 3) != 0);
      end
    end

    // Reset in the middle of a scan clears both banks and all outputs.
    clear_table();
    table_m[3] = '{60, 60, 8, 8, 6, 1};
    do_frame(1'b0);
    query(124, 124, 1'b1);
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    for (int k = 0; k < 20 && int'(bullet_index) != 4; k++) @(negedge clk);
    chk("reached_index4", int'(bullet_index), 4);
    rst_n = 1'b0;
    #1;
    chk("midrst_bullet_index", int'(bullet_index), 0);
    chk("midrst_scan_busy", int'(scan_busy), 0);
    chk("midrst_pixel_hit", int'(pixel_hit), 0);
    chk("midrst_pixel_color", int'(pixel_color), 0);
    chk("midrst_collide", int'(collide), 0);
    chk("midrst_collide_index", int'(collide_index), 0);
    @(negedge clk) rst_n = 1'b1;
    clear_table();
    snap = table_m;
    last_cidx = 0;
    query(124, 124, 1'b1);
    repeat (4) @(negedge clk);
    chk("post_rst_collide", int'(collide), 0);
    chk("post_rst_busy", int'(scan_busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
